// File: rtl/multicycle_control_unit_if.sv
// Instruction handshake, memory handshake and datapath-control bundle for the
// multi-cycle control unit. The control unit is the slave; the datapath/sequencer is the master.
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 3
) ();
    logic                instr_valid;
    logic [OPCODE_W-1:0] opcode;
    logic                instr_ready;
    logic                zero;
    logic                mem_ready;
    logic                ir_write;
    logic                pc_write;
    logic                pc_src;
    logic                reg_dest;
    logic                alusrc;
    logic                mem_to_reg;
    logic                reg_wr;
    logic                mem_rd;
    logic                mem_wr;
    logic                branch_taken;
    logic [ALUOP_W-1:0]  alu_op;
    logic                illegal;
    logic                fault;
    logic [2:0]          state;

    modport master (
        output instr_valid, opcode, zero, mem_ready,
        input  instr_ready, ir_write, pc_write, pc_src, reg_dest, alusrc, mem_to_reg,
               reg_wr, mem_rd, mem_wr, branch_taken, alu_op, illegal, fault, state
    );

    modport slave (
        input  instr_valid, opcode, zero, mem_ready,
        output instr_ready, ir_write, pc_write, pc_src, reg_dest, alusrc, mem_to_reg,
               reg_wr, mem_rd, mem_wr, branch_taken, alu_op, illegal, fault, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle miniMIPS main control: accept/DECODE/EXEC/MEM/WB sequencing with
// memory wait timeout into a sticky FAULT state and single-cycle illegal-opcode rejection.
module multicycle_control_unit #(
    parameter int OPCODE_W    = 4,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 8
) (
    input logic                      clk,
    input logic                      reset,
    multicycle_control_unit_if.slave bus
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic [2:0]          r_state;
    logic [OPCODE_W-1:0] r_opcode;
    logic [CNT_W-1:0]    r_wait;
    logic                r_fault;

    logic       w_hi_ok, w_bad_lo, w_illegal;
    logic       w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_beq, w_is_bne;
    logic       w_map_alusrc, w_map_regdest, w_taken;
    logic [2:0] w_map_aluop, w_alu_op;

    // Opcode classification; any set bit above [3:0] makes the opcode illegal.
    always_comb begin
        w_hi_ok       = ((r_opcode >> 4) == {OPCODE_W{1'b0}});
        w_bad_lo      = 1'b0;
        w_is_r        = 1'b0;
        w_is_i        = 1'b0;
        w_is_lw       = 1'b0;
        w_is_sw       = 1'b0;
        w_is_beq      = 1'b0;
        w_is_bne      = 1'b0;
        w_map_alusrc  = 1'b0;
        w_map_regdest = 1'b0;
        w_map_aluop   = 3'b000;
        case (r_opcode[3:0])
            4'b0000: begin w_is_r = w_hi_ok; w_map_regdest = 1'b1; end
            4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0111: begin
                w_is_i       = w_hi_ok;
                w_map_alusrc = 1'b1;
                w_map_aluop  = r_opcode[2:0];
            end
            4'b1000: begin w_is_lw = w_hi_ok; w_map_alusrc = 1'b1; w_map_aluop = 3'b001; end
            4'b1001: begin w_is_sw = w_hi_ok; w_map_alusrc = 1'b1; w_map_aluop = 3'b001; end
            4'b0101: begin w_is_beq = w_hi_ok; w_map_aluop = 3'b110; end
            4'b0110: begin w_is_bne = w_hi_ok; w_map_aluop = 3'b110; end
            default: w_bad_lo = 1'b1;
        endcase
        w_illegal = w_bad_lo | ~w_hi_ok;
        w_taken   = bus.zero ^ w_is_bne;
    end

    // Per-state datapath controls, decoded from the state register and latched opcode.
    always_comb begin
        bus.instr_ready  = 1'b0;
        bus.ir_write     = 1'b0;
        bus.pc_write     = 1'b0;
        bus.pc_src       = 1'b0;
        bus.reg_dest     = 1'b0;
        bus.alusrc       = 1'b0;
        bus.mem_to_reg   = 1'b0;
        bus.reg_wr       = 1'b0;
        bus.mem_rd       = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.branch_taken = 1'b0;
        bus.illegal      = 1'b0;
        w_alu_op         = 3'b000;
        case (r_state)
            S_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid && !reset) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                end else begin
                    bus.ir_write = 1'b0;
                end
            end
            S_DECODE: bus.illegal = w_illegal;
            S_EXEC: begin
                w_alu_op     = w_map_aluop;
                bus.alusrc   = w_map_alusrc;
                bus.reg_dest = w_map_regdest;
                if (w_is_beq || w_is_bne) begin
                    bus.branch_taken = w_taken;
                    bus.pc_write     = w_taken;
                    bus.pc_src       = w_taken;
                end else begin
                    bus.branch_taken = 1'b0;
                end
            end
            S_MEM: begin
                bus.alusrc = 1'b1;
                w_alu_op   = 3'b001;
                bus.mem_rd = w_is_lw;
                bus.mem_wr = w_is_sw;
            end
            S_WB: begin
                bus.reg_wr     = 1'b1;
                bus.mem_to_reg = w_is_lw;
                bus.reg_dest   = w_map_regdest;
                bus.alusrc     = w_map_alusrc;
                w_alu_op       = w_map_aluop;
            end
            default: w_alu_op = 3'b000;
        endcase
    end

    assign bus.alu_op = ALUOP_W'(w_alu_op);
    assign bus.fault  = r_fault;
    assign bus.state  = r_state;

    // Sequencer: state, latched opcode, MEM wait counter and sticky fault flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_opcode <= {OPCODE_W{1'b0}};
            r_wait   <= {CNT_W{1'b0}};
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        r_opcode <= bus.opcode;
                        r_state  <= S_DECODE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DECODE: r_state <= w_illegal ? S_IDLE : S_EXEC;
                S_EXEC: begin
                    if (w_is_beq || w_is_bne) begin
                        r_state <= S_IDLE;
                    end else if (w_is_lw || w_is_sw) begin
                        r_state <= S_MEM;
                        r_wait  <= {CNT_W{1'b0}};
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        r_state <= w_is_lw ? S_WB : S_IDLE;
                    end else if (r_wait == CNT_W'(MEM_TIMEOUT - 1)) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_wait <= r_wait + CNT_W'(1);
                    end
                end
                S_WB:    r_state <= S_IDLE;
                S_FAULT: begin
                    r_state <= S_FAULT;
                    r_fault <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class, memory wait,
// timeout fault, illegal opcodes (4- and 6-bit opcode instances) and asynchronous reset.
module tb_multicycle_control_unit;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    multicycle_control_unit_if #(.OPCODE_W(4), .ALUOP_W(3)) bus0 ();
    multicycle_control_unit_if #(.OPCODE_W(6), .ALUOP_W(3)) bus1 ();

    multicycle_control_unit #(.OPCODE_W(4), .ALUOP_W(3), .MEM_TIMEOUT(8)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(3), .MEM_TIMEOUT(8)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    // {ir_write, pc_write,pc_src,reg_dest,alusrc, mem_to_reg,reg_wr,mem_rd,mem_wr,
    //  branch_taken,illegal,fault,instr_ready}
    logic [12:0] ctl0;
    assign ctl0 = {bus0.ir_write, bus0.pc_write, bus0.pc_src, bus0.reg_dest, bus0.alusrc,
                   bus0.mem_to_reg, bus0.reg_wr, bus0.mem_rd, bus0.mem_wr,
                   bus0.branch_taken, bus0.illegal, bus0.fault, bus0.instr_ready};

    localparam logic [12:0] C_IDLE   = 13'b0_0000_0000_0001;
    localparam logic [12:0] C_ACCEPT = 13'b1_1000_0000_0001;
    localparam logic [12:0] C_NONE   = 13'b0_0000_0000_0000;
    localparam logic [12:0] C_FAULT  = 13'b0_0000_0000_0010;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_step(input string tag, input logic [2:0] st, input logic [12:0] c,
                            input logic [2:0] alu);
        chk({tag, ".state"}, 32'(bus0.state), 32'(st));
        chk({tag, ".ctl"}, 32'(ctl0), 32'(c));
        chk({tag, ".alu_op"}, 32'(bus0.alu_op), 32'(alu));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present an opcode in IDLE, check the accept-cycle controls, then drop valid.
    task automatic accept(input string tag, input logic [3:0] op);
        bus0.opcode      = op;
        bus0.instr_valid = 1'b1;
        #1;
        chk_step({tag, ".accept"}, 3'd0, C_ACCEPT, 3'b000);
        tick();
        bus0.instr_valid = 1'b0;
        bus0.opcode      = 4'hF;
    endtask

    initial begin
        bus0.instr_valid = 1'b0; bus0.opcode = 4'h0; bus0.zero = 1'b0; bus0.mem_ready = 1'b0;
        bus1.instr_valid = 1'b0; bus1.opcode = 6'h0; bus1.zero = 1'b0; bus1.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_step("reset", 3'd0, C_IDLE, 3'b000);
        reset = 1'b0;

        // R-type
        accept("rtype", 4'b0000);
        chk_step("rtype.decode", 3'd1, C_NONE, 3'b000);
        tick(); chk_step("rtype.exec", 3'd2, 13'b0_0010_0000_0000, 3'b000);
        tick(); chk_step("rtype.wb", 3'd4, 13'b0_0010_0100_0000, 3'b000);
        tick(); chk_step("rtype.done", 3'd0, C_IDLE, 3'b000);

        // I-type 0011
        accept("itype", 4'b0011);
        tick(); chk_step("itype.exec", 3'd2, 13'b0_0001_0000_0000, 3'b011);
        tick(); chk("itype.wb.state", 32'(bus0.state), 32'd4);
        chk("itype.wb.reg_wr", 32'(bus0.reg_wr), 32'd1);
        tick(); chk_step("itype.done", 3'd0, C_IDLE, 3'b000);

        // lw with two wait cycles
        accept("lw", 4'b1000);
        tick(); chk_step("lw.exec", 3'd2, 13'b0_0001_0000_0000, 3'b001);
        tick(); chk_step("lw.mem0", 3'd3, 13'b0_0001_0010_0000, 3'b001);
        tick(); chk_step("lw.mem1", 3'd3, 13'b0_0001_0010_0000, 3'b001);
        tick(); bus0.mem_ready = 1'b1; #1;
        chk_step("lw.mem2", 3'd3, 13'b0_0001_0010_0000, 3'b001);
        tick(); bus0.mem_ready = 1'b0;
        chk("lw.wb.state", 32'(bus0.state), 32'd4);
        chk("lw.wb.reg_wr", 32'(bus0.reg_wr), 32'd1);
        chk("lw.wb.mem_to_reg", 32'(bus0.mem_to_reg), 32'd1);
        chk("lw.wb.mem_rd", 32'(bus0.mem_rd), 32'd0);
        tick(); chk_step("lw.done", 3'd0, C_IDLE, 3'b000);

        // sw with immediate mem_ready
        bus0.mem_ready = 1'b1;
        accept("sw", 4'b1001);
        tick(); chk_step("sw.exec", 3'd2, 13'b0_0001_0000_0000, 3'b001);
        tick(); chk_step("sw.mem", 3'd3, 13'b0_0001_0001_0000, 3'b001);
        tick(); chk_step("sw.done", 3'd0, C_IDLE, 3'b000);
        bus0.mem_ready = 1'b0;

        // Branches
        bus0.zero = 1'b1;
        accept("beq_z1", 4'b0101);
        tick(); chk_step("beq_z1.exec", 3'd2, 13'b0_1100_0000_1000, 3'b110);
        tick(); chk_step("beq_z1.done", 3'd0, C_IDLE, 3'b000);
        accept("bne_z1", 4'b0110);
        tick(); chk_step("bne_z1.exec", 3'd2, C_NONE, 3'b110);
        tick(); chk_step("bne_z1.done", 3'd0, C_IDLE, 3'b000);
        bus0.zero = 1'b0;
        accept("bne_z0", 4'b0110);
        tick(); chk_step("bne_z0.exec", 3'd2, 13'b0_1100_0000_1000, 3'b110);
        tick(); chk_step("bne_z0.done", 3'd0, C_IDLE, 3'b000);

        // Illegal opcode on the 4-bit instance
        accept("ill", 4'b1111);
        chk_step("ill.decode", 3'd1, 13'b0_0000_0000_0100, 3'b000);
        tick(); chk_step("ill.done", 3'd0, C_IDLE, 3'b000);

        // 6-bit instance: upper bit set is illegal, clean 000001 is legal
        bus1.opcode = 6'b010001; bus1.instr_valid = 1'b1;
        tick(); bus1.instr_valid = 1'b0;
        chk("op6_ill.state", 32'(bus1.state), 32'd1);
        chk("op6_ill.illegal", 32'(bus1.illegal), 32'd1);
        tick(); chk("op6_ill.done", 32'(bus1.state), 32'd0);
        bus1.opcode = 6'b000001; bus1.instr_valid = 1'b1;
        tick(); bus1.instr_valid = 1'b0;
        chk("op6_ok.illegal", 32'(bus1.illegal), 32'd0);
        tick(); chk("op6_ok.exec", 32'(bus1.state), 32'd2);
        chk("op6_ok.alu_op", 32'(bus1.alu_op), 32'd1);

        // lw timeout: 8 MEM cycles then sticky FAULT
        accept("to", 4'b1000);
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("to.mem%0d.state", i), 32'(bus0.state), 32'd3);
            chk($sformatf("to.mem%0d.mem_rd", i), 32'(bus0.mem_rd), 32'd1);
        end
        tick(); chk_step("to.fault", 3'd5, C_FAULT, 3'b000);
        bus0.opcode = 4'b0000; bus0.instr_valid = 1'b1;
        tick(); tick();
        bus0.instr_valid = 1'b0;
        chk_step("to.sticky", 3'd5, C_FAULT, 3'b000);
        #2 reset = 1'b1;
        #1 chk_step("to.reset", 3'd0, C_IDLE, 3'b000);
        @(posedge clk); #1 reset = 1'b0;

        // Asynchronous reset in the middle of a sw MEM wait
        accept("swr", 4'b1001);
        tick(); tick();
        chk_step("swr.mem", 3'd3, 13'b0_0001_0001_0000, 3'b001);
        #2 reset = 1'b1;
        #1 chk_step("swr.reset", 3'd0, C_IDLE, 3'b000);
        @(posedge clk); #1 reset = 1'b0;

        // Normal instruction after reset
        accept("post", 4'b0000);
        chk_step("post.decode", 3'd1, C_NONE, 3'b000);
        tick(); chk_step("post.exec", 3'd2, 13'b0_0010_0000_0000, 3'b000);
        tick(); chk_step("post.wb", 3'd4, 13'b0_0010_0100_0000, 3'b000);
        tick(); chk_step("post.done", 3'd0, C_IDLE, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle successor to the single-cycle miniMIPS main control unit.
- Accepts one opcode per instruction through a valid/ready handshake and sequences FETCH-accept, DECODE, EXEC, MEM and WB steps.
- Drives the same datapath controls per step, adds variable-latency memory handshake with timeout and an illegal-opcode path.

Parameters:
- OPCODE_W, 4, opcode width (>=4); any nonzero bit above [3:0] makes the opcode illegal.
- ALUOP_W, 3, alu_op width (>=3); the 3-bit code is zero-extended.
- MEM_TIMEOUT, 8, max MEM cycles waiting for mem_ready (>=1) before FAULT.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  opcode presented.
- opcode  in  OPCODE_W  instruction opcode.
- instr_ready  out  1  unit can accept an opcode.
- zero  in  1  ALU zero flag, sampled in EXEC.
- mem_ready  in  1  memory completed the current access.
- ir_write  out  1  latch instruction register (accept cycle).
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- reg_dest, alusrc, mem_to_reg, reg_wr, mem_rd, mem_wr  out  1 each  datapath controls.
- branch_taken  out  1  branch resolved taken.
- alu_op  out  ALUOP_W  ALU operation.
- illegal  out  1  one-cycle pulse: opcode rejected.
- fault  out  1  memory timeout; sticky until reset.
- state  out  3  current state encoding.

Behaviour:
- States: IDLE=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5. Codes 6 and 7 return to IDLE.
- Reset (async, any state) forces:
  - state IDLE.
  - opcode register, wait counter and fault cleared.
  - Outputs: instr_ready=1, all others 0.
- Outputs are combinational from state and the latched opcode. pc_write and branch_taken additionally use zero in EXEC.
- Opcode map on bits [3:0], with alu_op as a 3-bit code:
  - 0000 R-type: reg_dest=1, alu_op=000.
  - 0001, 0010, 0011, 0100, 0111 I-type: alusrc=1, alu_op=opcode[2:0].
  - 1000 lw, 1001 sw: alusrc=1, alu_op=001.
  - 0101 beq, 0110 bne: alu_op=110.
  - All other codes are illegal.
- IDLE:
  - instr_ready=1.
  - On instr_valid: ir_write=1, pc_write=1, pc_src=0, latch opcode, go to DECODE.
- DECODE:
  - If illegal: illegal=1 for this cycle, go to IDLE. No register or memory writes occur.
  - Otherwise go to EXEC.
- EXEC: alu_op, alusrc and reg_dest are per the map.
  - Branch: branch_taken = zero XOR is_bne. If taken, pc_write=1 and pc_src=1. Go to IDLE.
  - lw/sw: go to MEM. Wait counter cleared.
  - R-type and I-type: go to WB.
- MEM: alusrc=1, alu_op=001. mem_rd (lw) or mem_wr (sw) held high every MEM cycle.
  - mem_ready=1: lw goes to WB, sw goes to IDLE.
  - mem_ready=0 with count<MEM_TIMEOUT-1: count increments.
  - mem_ready=0 with count==MEM_TIMEOUT-1: go to FAULT.
- WB:
  - reg_wr=1 for exactly one cycle.
  - mem_to_reg=1 for lw, reg_dest=1 for R-type, alu_op held.
  - Go to IDLE.
- FAULT:
  - fault=1, instr_ready=0, all other controls 0.
  - Only reset exits.
- Latency from accept edge back to instr_ready:
  - Branch: 3 cycles.
  - R/I-type: 4 cycles.
  - sw: 4+w cycles; lw: 5+w cycles, where w = MEM cycles waiting with mem_ready low.
- instr_valid outside IDLE is ignored and nothing is latched. Changes to opcode after accept have no effect.

Test Plan:
- R-type 0000 accepted at cycle 0 -> DECODE(1), EXEC(2) with reg_dest=1 and alu_op=000, WB(3) with reg_wr=1 and reg_dest=1, instr_ready=1 at cycle 4.
- lw 1000 with mem_ready low 2 cycles, then high -> mem_rd=1 for 3 MEM cycles, then WB with reg_wr=1 and mem_to_reg=1. sw 1001 with mem_ready=1 immediately -> one MEM cycle with mem_wr=1, reg_wr never asserted, IDLE next.
- beq 0101 with zero=1 -> EXEC: branch_taken=1, pc_write=1, pc_src=1. bne 0110 with zero=1 -> branch_taken=0, pc_write=0. Both return to IDLE at cycle 3.
- Illegal opcode 1111 -> illegal=1 in DECODE cycle only, no reg_wr, mem_rd or mem_wr, IDLE at cycle 2. With OPCODE_W=6, opcode 6'b010001 -> illegal.
- lw with mem_ready held 0 and MEM_TIMEOUT=8 -> 8 MEM cycles, then FAULT with fault=1 and instr_ready=0. Further instr_valid ignored. Reset -> IDLE, fault=0.
- Reset asserted mid-MEM of sw -> mem_wr drops immediately (asynchronous), state=0, instr_ready=1. The next instruction executes normally.
